axil_regfile_slave: RTL and testbench
=====================================

Name: axil_regfile_slave

Overview:
Parametrised AXI-lite-style register-file slave. It is the next generation of the 3-bit-address, 4-bit-data slave that feeds the seven-segment display path. It adds:
- independent AW/W acceptance
- error responses for unmapped addresses
- configurable depth and width
- a dedicated display read port, so the display can monitor any register without bus traffic

It sits between the bus master and the display decoder.

Parameters:
ADDR_W, 3, address width in bits
DATA_W, 4, register/data width in bits; must be a multiple of 4
NUM_REGS, 8, number of implemented registers, 1..2^ADDR_W; addresses >= NUM_REGS are unmapped

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
aw_valid  in  1  write address valid
aw_ready  out  1  write address ready
aw_addr  in  ADDR_W  write address
w_valid  in  1  write data valid
w_ready  out  1  write data ready
w_data  in  DATA_W  write data
b_valid  out  1  write response valid
b_ready  in  1  write response ready
b_resp  out  2  00 OKAY, 10 SLVERR
ar_valid  in  1  read address valid
ar_ready  out  1  read address ready
ar_addr  in  ADDR_W  read address
r_valid  out  1  read data valid
r_ready  in  1  read data ready
r_data  out  DATA_W  read data
r_resp  out  2  00 OKAY, 10 SLVERR
disp_addr  in  ADDR_W  display monitor register select
disp_data  out  DATA_W  registered contents of the selected register

Behaviour:
Reset:
- rst sampled at rising clk only; synchronous, active-high.
- On reset, all registers = 0.
- aw_ready = 1, w_ready = 1, ar_ready = 1.
- b_valid = 0, r_valid = 0, b_resp = 00, r_resp = 00, r_data = 0, disp_data = 0.
- Reset mid-transaction abandons the transaction: pending AW/W captures cleared, no register write, valids drop the cycle after reset.

Write channel, FSM WR_IDLE -> WR_RESP:
- WR_IDLE: aw_ready high until an address is captured; w_ready high until data is captured.
- AW and W are captured independently, in any order or the same cycle. Each ready drops the cycle after its own handshake.
- On the edge where both are held or completing: if addr < NUM_REGS, write reg[addr] = w_data (subject to the optional feature), b_resp = 00; else no write, b_resp = 10.
- Same edge: b_valid = 1, state -> WR_RESP.
- Write latency: b_valid asserts 1 cycle after the later of the AW/W handshakes.
- WR_RESP: b_valid and b_resp held until b_valid & b_ready. Next edge: b_valid = 0, aw_ready = w_ready = 1, state -> WR_IDLE.
- No new AW/W is accepted while in WR_RESP.

Read channel, FSM RD_IDLE -> RD_DATA:
- RD_IDLE: ar_ready = 1.
- On ar handshake: r_data = reg[ar_addr] (0 if unmapped), r_resp = 00 or 10, r_valid = 1, ar_ready = 0, state -> RD_DATA.
- Read latency: 1 cycle.
- RD_DATA: r_data and r_resp held stable until r_valid & r_ready. Next edge: r_valid = 0, ar_ready = 1.
- Back-to-back throughput: one read every 2 cycles.

Simultaneous events:
- A read handshake on the same edge as a write commit to the same address returns the old value (read-before-write).
- Read and write channels are fully concurrent; neither stalls the other.

Display port:
- disp_data = reg[disp_addr] registered every cycle, 1-cycle latency; 0 for unmapped addresses.
- Reflects a write 1 cycle after the commit edge.

Width rules:
- Address compare is unsigned.
- When NUM_REGS = 2^ADDR_W, SLVERR never occurs.

Optional Feature:
Macro AXIL_WSTRB_EN.
- Defined: adds input w_strb, width DATA_W/4, one bit per 4-bit nibble lane, captured with w_data. Only nibbles whose strobe bit is 1 are updated. All-zero strobe on a mapped address: no change, b_resp = 00.
- Undefined: no w_strb port; every write updates all DATA_W bits.

Test Plan:
- Reset then read addr 0..7 -> each returns r_data = 0, r_resp = 00, r_valid 1 cycle after ar handshake.
- AW addr 3 cycle 0, W data 4'hA cycle 2, b_ready held 1 -> b_valid asserts cycle 3 with b_resp = 00. Subsequent read addr 3 -> 4'hA. disp_addr = 3 -> disp_data = 4'hA.
- NUM_REGS = 5: write addr 6 data 4'h7 -> b_resp = 10, no register changes. Read addr 6 -> r_data = 0, r_resp = 10.
- Hold b_ready = 0 and r_ready = 0 for 4 cycles -> b_valid/b_resp and r_valid/r_data remain stable. aw_ready = w_ready = 0 and ar_ready = 0 throughout.
- Reg 2 = 4'h5, then write 4'hC to addr 2 on the same edge as a read handshake for addr 2 -> r_data = 4'h5; next read -> 4'hC.
- AXIL_WSTRB_EN, DATA_W = 8: reg 1 = 8'h3C, write 8'hF0 with w_strb = 2'b10 -> reg 1 = 8'hFC. Assert rst during a pending AW-only capture -> no write, aw_ready = 1 after reset.

Source files
------------

// File: rtl/axil_regfile_slave.sv
// axil_regfile_slave: AXI-lite register file slave with independent AW/W capture, SLVERR for addr>=NUM_REGS, and registered display read port (disp_addr->disp_data); ports clk, rst, aw_*, w_*, b_*, ar_*, r_*, disp_*; AXIL_WSTRB_EN adds w_strb nibble-lane write strobes
module axil_regfile_slave #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 4,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
`ifdef AXIL_WSTRB_EN
  input  logic [DATA_W/4-1:0] w_strb,
`endif
  output logic              b_valid,
  input  logic              b_ready,
  output logic [1:0]        b_resp,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ADDR_W-1:0] ar_addr,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [DATA_W-1:0] r_data,
  output logic [1:0]        r_resp,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {WR_IDLE, WR_RESP} wr_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_e;
  wr_e wr_q;
  rd_e rd_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              aw_held_q, w_held_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
`ifdef AXIL_WSTRB_EN
  localparam int LANES = DATA_W / 4;
  logic [LANES-1:0]  wstrb_q;
`endif
  logic              aw_hs, w_hs, commit, wmap, rmap, dmap;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd, wmask;
  always_comb begin
    aw_hs  = aw_valid & aw_ready;
    w_hs   = w_valid & w_ready;
    wa     = aw_held_q ? awaddr_q : aw_addr;
    wd     = w_held_q ? wdata_q : w_data;
    commit = (wr_q == WR_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
    wmap   = 32'(wa) < NUM_REGS;
    rmap   = 32'(ar_addr) < NUM_REGS;
    dmap   = 32'(disp_addr) < NUM_REGS;
    wmask  = '1;
`ifdef AXIL_WSTRB_EN
    for (int i = 0; i < LANES; i++) wmask[i*4+:4] = {4{w_held_q ? wstrb_q[i] : w_strb[i]}};
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= WR_IDLE;
      aw_ready  <= 1'b1;
      w_ready   <= 1'b1;
      b_valid   <= 1'b0;
      b_resp    <= 2'b00;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
`ifdef AXIL_WSTRB_EN
      wstrb_q   <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_q == WR_RESP) begin
      if (b_ready) begin
        wr_q     <= WR_IDLE;
        b_valid  <= 1'b0;
        aw_ready <= 1'b1;
        w_ready  <= 1'b1;
      end
    end else if (commit) begin
      if (wmap) mem_q[wa] <= (mem_q[wa] & ~wmask) | (wd & wmask);
      b_resp    <= wmap ? 2'b00 : 2'b10;
      b_valid   <= 1'b1;
      wr_q      <= WR_RESP;
      aw_ready  <= 1'b0;
      w_ready   <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_ready  <= 1'b0;
        awaddr_q  <= aw_addr;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        w_ready  <= 1'b0;
        wdata_q  <= w_data;
`ifdef AXIL_WSTRB_EN
        wstrb_q  <= w_strb;
`endif
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q     <= RD_IDLE;
      ar_ready <= 1'b1;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_resp   <= 2'b00;
    end else if (rd_q == RD_IDLE) begin
      if (ar_valid) begin
        r_data   <= rmap ? mem_q[ar_addr] : '0;
        r_resp   <= rmap ? 2'b00 : 2'b10;
        r_valid  <= 1'b1;
        ar_ready <= 1'b0;
        rd_q     <= RD_DATA;
      end
    end else if (r_ready) begin
      r_valid  <= 1'b0;
      ar_ready <= 1'b1;
      rd_q     <= RD_IDLE;
    end
  end
  always_ff @(posedge clk) disp_data <= rst ? '0 : dmap ? mem_q[disp_addr] : '0;
endmodule

// File: tb/tb_axil_regfile_slave.sv
// tb_axil_regfile_slave: directed scoreboard bench for axil_regfile_slave with NUM_REGS=5
module tb_axil_regfile_slave;
  localparam int AW = 3;
  localparam int DW = 4;
  localparam int NR = 5;
  logic clk = 0;
  logic rst = 1;
  logic aw_valid = 0, w_valid = 0, ar_valid = 0, b_ready = 1, r_ready = 1;
  logic aw_ready, w_ready, ar_ready, b_valid, r_valid;
  logic [AW-1:0] aw_addr = '0, ar_addr = '0, disp_addr = '0;
  logic [DW-1:0] w_data = '0, r_data, disp_data;
  logic [1:0] b_resp, r_resp;
`ifdef AXIL_WSTRB_EN
  logic [DW/4-1:0] w_strb = '1;
`endif
  int total = 0;
  int bad = 0;
  logic [DW-1:0] model [8];
  logic [DW+1:0] rd_sb [$];
  logic [1:0] wr_sb [$];
  always #5 clk = ~clk;
  axil_regfile_slave #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
`ifdef AXIL_WSTRB_EN
    .w_strb(w_strb),
`endif
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .disp_addr(disp_addr), .disp_data(disp_data)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int ad, input int wd, input int hold);
    int n = 0;
    bit awd = 0, wdn = 0, ha, hw;
    logic [1:0] er;
    wr_sb.push_back(int'(a) < NR ? 2'b00 : 2'b10);
    if (int'(a) < NR) model[a] = d;
    b_ready = (hold == 0);
    while (!(awd && wdn) && n < 20) begin
      if (n == ad) begin aw_valid = 1; aw_addr = a; end
      if (n == wd) begin w_valid = 1; w_data = d; end
      if (awd) chk("aw_ready_after_hs", aw_ready, 0);
      if (wdn) chk("w_ready_after_hs", w_ready, 0);
      ha = aw_valid & aw_ready;
      hw = w_valid & w_ready;
      @(negedge clk);
      if (ha) begin aw_valid = 0; awd = 1; end
      if (hw) begin w_valid = 0; wdn = 1; end
      n++;
    end
    chk("b_valid_latency", b_valid, 1);
    er = wr_sb.pop_front();
    chk("b_resp", b_resp, er);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("b_valid_hold", b_valid, 1);
      chk("b_resp_hold", b_resp, er);
      chk("wr_readies_hold", {aw_ready, w_ready}, 0);
    end
    b_ready = 1;
    @(negedge clk);
    chk("b_done", {b_valid, aw_ready, w_ready}, 3'b011);
  endtask
  task automatic rd(input logic [AW-1:0] a, input int hold);
    logic [DW+1:0] e;
    rd_sb.push_back({(int'(a) < NR) ? model[a] : {DW{1'b0}}, (int'(a) < NR) ? 2'b00 : 2'b10});
    r_ready = (hold == 0);
    chk("ar_ready_idle", ar_ready, 1);
    ar_valid = 1;
    ar_addr = a;
    @(negedge clk);
    ar_valid = 0;
    chk("r_valid_latency", r_valid, 1);
    e = rd_sb.pop_front();
    chk("r_data", r_data, e[DW+1:2]);
    chk("r_resp", r_resp, e[1:0]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("r_valid_hold", r_valid, 1);
      chk("r_data_hold", r_data, e[DW+1:2]);
      chk("r_resp_hold", r_resp, e[1:0]);
      chk("ar_ready_hold", ar_ready, 0);
    end
    r_ready = 1;
    @(negedge clk);
    chk("r_done", {r_valid, ar_ready}, 2'b01);
  endtask
  initial begin
    logic [DW+1:0] e;
    for (int i = 0; i < 8; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_readies", {aw_ready, w_ready, ar_ready}, 3'b111);
    chk("rst_valids", {b_valid, r_valid}, 0);
    chk("rst_resps", {b_resp, r_resp}, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_disp", disp_data, 0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) rd(i[AW-1:0], 0);
    wr(3, 4'hA, 0, 2, 0);
    disp_addr = 3;
    @(negedge clk);
    chk("disp_reg3", disp_data, 4'hA);
    rd(3, 0);
    wr(1, 4'h6, 2, 0, 0);
    rd(1, 0);
    wr(0, 4'h3, 0, 0, 0);
    rd(0, 0);
    wr(6, 4'h7, 0, 0, 0);
    rd(6, 0);
    disp_addr = 6;
    @(negedge clk);
    chk("disp_unmapped", disp_data, 0);
    for (int i = 0; i < NR; i++) rd(i[AW-1:0], 0);
    wr(4, 4'h9, 0, 1, 4);
    rd(4, 4);
    wr(2, 4'h5, 0, 0, 0);
    rd_sb.push_back({4'h5, 2'b00});
    wr_sb.push_back(2'b00);
    model[2] = 4'hC;
    aw_valid = 1; aw_addr = 2; w_valid = 1; w_data = 4'hC; ar_valid = 1; ar_addr = 2;
    @(negedge clk);
    aw_valid = 0; w_valid = 0; ar_valid = 0;
    chk("concurrent_valids", {b_valid, r_valid}, 2'b11);
    e = rd_sb.pop_front();
    chk("rbw_r_data", r_data, e[DW+1:2]);
    chk("concurrent_b_resp", b_resp, wr_sb.pop_front());
    @(negedge clk);
    chk("concurrent_done", {b_valid, r_valid}, 0);
    rd(2, 0);
    disp_addr = 2;
    @(negedge clk);
    chk("disp_reg2", disp_data, 4'hC);
    aw_valid = 1; aw_addr = 1;
    @(negedge clk);
    aw_valid = 0;
    chk("aw_only_held", {aw_ready, w_ready}, 2'b01);
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    chk("mid_rst_readies", {aw_ready, w_ready, ar_ready}, 3'b111);
    w_valid = 1; w_data = 4'hF;
    @(negedge clk);
    w_valid = 0;
    chk("no_commit_after_rst", b_valid, 0);
    chk("w_only_held", {aw_ready, w_ready}, 2'b10);
    rst = 1;
    @(negedge clk);
    rst = 0;
    rd(1, 0);
    rd(3, 0);
    wr(1, 4'hE, 0, 0, 0);
    rd(1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
